piso_serializer: RTL and testbench

Parallel-in, serial-out stage that sits directly upstream of the team's serial sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a serial line. The detector samples that line every cycle. Between words the line holds a fixed idle level, so idle periods produce no spurious patterns.

---
 rtl/piso_serializer.sv | 128 ++++++++++++
 tb/tb_piso_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out stage feeding the serial sequence detectors. A
// WIDTH-bit word is accepted over a valid/ready handshake and sent one bit per
// clock on ser_out. Between words ser_out rests at IDLE_BIT, so the detector
// downstream never sees a spurious pattern while the line is idle.
//
// Parameters:
//   WIDTH     - word width in bits (2..32)
//   MSB_FIRST - 1: din[WIDTH-1] goes out first, 0: din[0] goes out first
//   IDLE_BIT  - level held on ser_out when no word is in flight
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   din        - parallel word to serialise
//   din_valid  - din holds a word to send
//   din_ready  - a word can be accepted this cycle (combinational)
//   ser_out    - registered serial data
//   ser_valid  - registered, high while ser_out carries a data bit
//   busy       - high while a word is being shifted out
//   frame_done - registered one-cycle pulse in the cycle after a word's last bit
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    count, count_next;
    logic             ser_out_next;
    logic             ser_valid_next;
    logic             frame_done_next;
    logic             at_last;
    logic             accept;

    // count tracks which bit of the current word is on ser_out, so the
    // last-bit cycle is the one place inside a word where a new word may load.
    assign at_last   = (state == SHIFT) && (count == LAST);
    assign din_ready = (state == IDLE) || at_last;
    assign accept    = din_valid && din_ready;
    assign busy      = (state == SHIFT);

    // Next-state logic. A load puts the first bit straight onto ser_out and
    // keeps the remaining bits in the shift register, aligned so the next bit
    // to send always sits at the end selected by MSB_FIRST. Loading in the
    // last-bit cycle gives gapless back-to-back words.
    always_comb begin
        state_next      = state;
        shift_next      = shift_reg;
        count_next      = count;
        ser_out_next    = ser_out;
        ser_valid_next  = ser_valid;
        frame_done_next = at_last;

        if (accept) begin
            state_next     = SHIFT;
            count_next     = '0;
            ser_valid_next = 1'b1;
            if (MSB_FIRST) begin
                ser_out_next = din[WIDTH-1];
                shift_next   = din << 1;
            end else begin
                ser_out_next = din[0];
                shift_next   = din >> 1;
            end
        end else if (at_last) begin
            state_next     = IDLE;
            count_next     = '0;
            ser_out_next   = IDLE_BIT;
            ser_valid_next = 1'b0;
        end else if (state == SHIFT) begin
            count_next = count + CW'(1);
            if (MSB_FIRST) begin
                ser_out_next = shift_reg[WIDTH-1];
                shift_next   = shift_reg << 1;
            end else begin
                ser_out_next = shift_reg[0];
                shift_next   = shift_reg >> 1;
            end
        end else begin
            ser_out_next   = IDLE_BIT;
            ser_valid_next = 1'b0;
        end
    end

    // State and output registers; reset drops any word in flight without
    // raising frame_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            count      <= '0;
            ser_out    <= IDLE_BIT;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            count      <= count_next;
            ser_out    <= ser_out_next;
            ser_valid  <= ser_valid_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//
// Drives two serializers (MSB-first and LSB-first, WIDTH=8) with the same
// stimulus and compares every cycle against a queue-based reference: an
// accepted word becomes eight queued bits, one leaves the queue per clock,
// and a new word is taken only when nothing is left queued.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, ser_out, ser_valid, busy, frame_done;
    logic       din_ready_l, ser_out_l, ser_valid_l, busy_l, frame_done_l;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dutLsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready_l),
        .ser_out    (ser_out_l),
        .ser_valid  (ser_valid_l),
        .busy       (busy_l),
        .frame_done (frame_done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic bitMsb;
        logic bitLsb;
        logic last;
    } item_t;

    item_t   pend[$];
    item_t   cur;
    bit      curValid;
    bit      fdExp;
    bit      modelLive;
    bit      modelAccepted;

    int          checks;
    int          failures;
    logic [15:0] capMsb;
    logic [15:0] capLsb;
    int          capCount;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: advance one clock edge given the inputs seen at that edge.
    task automatic modelStep(input bit rstAct, input bit vld, input logic [7:0] data);
        item_t it;
        modelAccepted = 1'b0;
        if (rstAct) begin
            pend.delete();
            curValid  = 1'b0;
            fdExp     = 1'b0;
            modelLive = 1'b1;
        end else if (modelLive) begin
            fdExp = curValid && cur.last;
            if (vld && pend.size() == 0) begin
                for (int i = 0; i < 8; i++) begin
                    it.bitMsb = data[7-i];
                    it.bitLsb = data[i];
                    it.last   = (i == 7);
                    pend.push_back(it);
                end
                modelAccepted = 1'b1;
            end
            if (pend.size() > 0) begin
                cur      = pend.pop_front();
                curValid = 1'b1;
            end else begin
                curValid = 1'b0;
            end
        end
    endtask

    // Compare both DUTs with the reference for the current cycle and record
    // the serial stream for the directed stream checks.
    task automatic checkCycle();
        logic expMsb, expLsb, expReady;
        if (modelLive) begin
            expMsb   = curValid ? cur.bitMsb : 1'b1;
            expLsb   = curValid ? cur.bitLsb : 1'b1;
            expReady = (pend.size() == 0);
            checkOutput("ser_out",        32'(ser_out),      32'(expMsb));
            checkOutput("ser_valid",      32'(ser_valid),    32'(curValid));
            checkOutput("busy",           32'(busy),         32'(curValid));
            checkOutput("frame_done",     32'(frame_done),   32'(fdExp));
            checkOutput("din_ready",      32'(din_ready),    32'(expReady));
            checkOutput("lsb_ser_out",    32'(ser_out_l),    32'(expLsb));
            checkOutput("lsb_ser_valid",  32'(ser_valid_l),  32'(curValid));
            checkOutput("lsb_busy",       32'(busy_l),       32'(curValid));
            checkOutput("lsb_frame_done", 32'(frame_done_l), 32'(fdExp));
            checkOutput("lsb_din_ready",  32'(din_ready_l),  32'(expReady));
        end
        if (ser_valid === 1'b1) begin
            capMsb   = {capMsb[14:0], ser_out};
            capLsb   = {capLsb[14:0], ser_out_l};
            capCount++;
        end
    endtask

    // One cycle: check what the last edge produced, then drive the inputs
    // for the next edge and advance the reference to match.
    task automatic applyStimulus(input bit rstAct, input bit vld, input logic [7:0] data);
        @(negedge clk);
        checkCycle();
        rst_n     = !rstAct;
        din_valid = vld;
        din       = data;
        modelStep(rstAct, vld, data);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'(($urandom)));
    endtask

    // Holds din_valid with data until the word is taken, bounded.
    task automatic sendWord(input logic [7:0] data);
        int tries;
        tries = 0;
        do begin
            applyStimulus(1'b0, 1'b1, data);
            tries++;
        end while (!modelAccepted && tries < 20);
        checkOutput("send_accept", 32'(modelAccepted), 32'd1);
    endtask

    task automatic clearCapture();
        capMsb   = '0;
        capLsb   = '0;
        capCount = 0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        modelLive = 1'b0;
        curValid  = 1'b0;
        fdExp     = 1'b0;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        clearCapture();

        // Reset held with din_valid asserted: nothing may be accepted.
        applyStimulus(1'b1, 1'b1, 8'h55);
        applyStimulus(1'b1, 1'b1, 8'h55);
        idleCycles(2);

        // Single word A0.
        clearCapture();
        sendWord(8'hA0);
        idleCycles(10);
        checkOutput("a0_msb_stream", 32'(capMsb[7:0]), 32'h00A0);
        checkOutput("a0_lsb_stream", 32'(capLsb[7:0]), 32'h0005);
        checkOutput("a0_bit_count",  32'(capCount),    32'd8);

        // Back-to-back A5 then 3C.
        clearCapture();
        sendWord(8'hA5);
        sendWord(8'h3C);
        idleCycles(10);
        checkOutput("b2b_stream",    32'(capMsb), 32'h0000A53C);
        checkOutput("b2b_bit_count", 32'(capCount), 32'd16);

        // Request presented three cycles into a word is held off.
        clearCapture();
        sendWord(8'hA5);
        idleCycles(2);
        sendWord(8'hFF);
        idleCycles(10);
        checkOutput("holdoff_stream", 32'(capMsb), 32'h0000A5FF);

        // LSB-first ordering of 01.
        clearCapture();
        sendWord(8'h01);
        idleCycles(10);
        checkOutput("lsb01_stream", 32'(capLsb[7:0]), 32'h0080);
        checkOutput("msb01_stream", 32'(capMsb[7:0]), 32'h0001);

        // Reset at the edge ending the 4th bit, then a fresh word.
        sendWord(8'hA5);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 8'h00);
        clearCapture();
        sendWord(8'h3C);
        idleCycles(10);
        checkOutput("post_reset_stream", 32'(capMsb[7:0]), 32'h003C);
        checkOutput("post_reset_count",  32'(capCount),    32'd8);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 3) != 0),
                          8'($urandom));
        end
        idleCycles(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
